// File: rtl/mov_avg4.sv
// Streaming 4-sample moving average with valid/ready handshakes.
// One-cycle latency; y_warm flags a fully populated window.
module mov_avg4 #(
   parameter int WIDTH = 16,
   parameter int LOG2N = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] x_data,
   input  logic                    x_valid,
   output logic                    x_ready,
   output logic signed [WIDTH-1:0] y_data,
   output logic                    y_valid,
   input  logic                    y_ready,
   output logic                    y_warm
);

   localparam int N  = 1 << LOG2N;
   localparam int AW = WIDTH + LOG2N;
   localparam int CW = LOG2N + 1;

   logic signed [WIDTH-1:0] w [N];
   logic signed [AW-1:0]    acc;
   logic signed [AW-1:0]    acc_nx;
   logic signed [AW-1:0]    xs;
   logic signed [AW-1:0]    os;
   logic [CW-1:0]           cnt;
   logic [CW-1:0]           cnt_nx;
   logic                    acc_in;

   assign x_ready = !y_valid || y_ready;
   assign acc_in  = x_valid && x_ready;

   assign xs     = AW'(x_data);
   assign os     = AW'(w[N-1]);
   assign acc_nx = acc + xs - os;
   assign cnt_nx = (cnt == CW'(N)) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            w[i] <= '0;
         end
         acc     <= '0;
         cnt     <= '0;
         y_data  <= '0;
         y_valid <= 1'b0;
         y_warm  <= 1'b0;
      end else if (acc_in) begin
         w[0] <= x_data;
         for (int i = 1; i < N; i++) begin
            w[i] <= w[i-1];
         end
         acc     <= acc_nx;
         cnt     <= cnt_nx;
         // floor division by N; the result always fits WIDTH bits
         y_data  <= WIDTH'(acc_nx >>> LOG2N);
         y_valid <= 1'b1;
         y_warm  <= (cnt_nx == CW'(N));
      end else if (y_ready) begin
         y_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mov_avg4.sv
// Directed bench for mov_avg4: reset, step, extremes, rounding,
// backpressure and mid-stream reset.
module tb_mov_avg4;

   logic               clk;
   logic               rst;
   logic signed [15:0] x_data;
   logic               x_valid;
   logic               x_ready;
   logic signed [15:0] y_data;
   logic               y_valid;
   logic               y_ready;
   logic               y_warm;

   int passed;
   int total;

   mov_avg4 #(.WIDTH(16), .LOG2N(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .x_data  (x_data),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_warm  (y_warm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b1;
      x_valid = 1'b0;
      x_data  = '0;
      y_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst     = 1'b1;
      x_valid = 1'b0;
      y_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      total++;
      if (y_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", y_valid);
      else passed++;
      total++;
      if (y_warm !== 1'b0) $display("FAIL rst_warm: got %b want 0", y_warm);
      else passed++;
      total++;
      if (x_ready !== 1'b1) $display("FAIL rst_xready: got %b want 1", x_ready);
      else passed++;
      total++;
      if (y_data !== 16'sd0) $display("FAIL rst_data: got %0d want 0", y_data);
      else passed++;
   endtask

   task automatic test_step();
      logic signed [15:0] ey [6] = '{25, 50, 75, 100, 100, 100};
      logic               ew [6] = '{0, 0, 0, 1, 1, 1};
      apply_reset();
      x_valid = 1'b1;
      x_data  = 16'sd100;
      y_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (y_valid !== 1'b1 || y_data !== ey[i])
            $display("FAIL step_%0d: got %0d/v%b want %0d/v1",
                     i, y_data, y_valid, ey[i]);
         else passed++;
         total++;
         if (y_warm !== ew[i])
            $display("FAIL step_warm_%0d: got %b want %b", i, y_warm, ew[i]);
         else passed++;
      end
      x_valid = 1'b0;
   endtask

   task automatic test_extremes();
      logic signed [15:0] xi [8] = '{32767, 32767, 32767, 32767,
                                     -32768, -32768, -32768, -32768};
      logic signed [15:0] ey [8] = '{8191, 16383, 24575, 32767,
                                     16383, -1, -16385, -32768};
      apply_reset();
      y_ready = 1'b1;
      x_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x_data = xi[i];
         @(negedge clk);
         total++;
         if (y_valid !== 1'b1 || y_data !== ey[i])
            $display("FAIL extreme_%0d: got %0d/v%b want %0d/v1",
                     i, y_data, y_valid, ey[i]);
         else passed++;
      end
      x_valid = 1'b0;
   endtask

   task automatic test_neg_round();
      apply_reset();
      y_ready = 1'b1;
      x_valid = 1'b1;
      x_data  = -16'sd1;
      @(negedge clk);
      total++;
      if (y_valid !== 1'b1 || y_data !== -16'sd1)
         $display("FAIL neg_round: got %0d/v%b want -1/v1", y_data, y_valid);
      else passed++;
      x_valid = 1'b0;
      @(negedge clk);
      total++;
      if (y_valid !== 1'b0)
         $display("FAIL gap_valid: got %b want 0", y_valid);
      else passed++;
      x_valid = 1'b1;
      x_data  = 16'sd5;
      @(negedge clk);
      total++;
      if (y_valid !== 1'b1 || y_data !== 16'sd1)
         $display("FAIL gap_window: got %0d/v%b want 1/v1", y_data, y_valid);
      else passed++;
      x_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      y_ready = 1'b1;
      x_valid = 1'b1;
      x_data  = 16'sd4;
      @(negedge clk);
      total++;
      if (y_valid !== 1'b1 || y_data !== 16'sd1)
         $display("FAIL bp_first: got %0d/v%b want 1/v1", y_data, y_valid);
      else passed++;
      y_ready = 1'b0;
      x_data  = 16'sd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (x_ready !== 1'b0)
            $display("FAIL bp_xready_%0d: got %b want 0", i, x_ready);
         else passed++;
         @(negedge clk);
         total++;
         if (y_valid !== 1'b1 || y_data !== 16'sd1)
            $display("FAIL bp_hold_%0d: got %0d/v%b want 1/v1",
                     i, y_data, y_valid);
         else passed++;
      end
      y_ready = 1'b1;
      #1;
      total++;
      if (x_ready !== 1'b1)
         $display("FAIL bp_release: got %b want 1", x_ready);
      else passed++;
      @(negedge clk);
      x_valid = 1'b0;
      total++;
      if (y_valid !== 1'b1 || y_data !== 16'sd2)
         $display("FAIL bp_one7: got %0d/v%b want 2/v1", y_data, y_valid);
      else passed++;
      @(negedge clk);
      total++;
      if (y_valid !== 1'b0)
         $display("FAIL bp_drain: got %b want 0", y_valid);
      else passed++;
   endtask

   task automatic test_midreset();
      apply_reset();
      y_ready = 1'b1;
      x_valid = 1'b1;
      x_data  = 16'sd100;
      repeat (2) @(negedge clk);
      total++;
      if (y_data !== 16'sd50)
         $display("FAIL mid_pre: got %0d want 50", y_data);
      else passed++;
      x_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (y_valid !== 1'b0)
         $display("FAIL mid_flush: got %b want 0", y_valid);
      else passed++;
      x_valid = 1'b1;
      @(negedge clk);
      x_valid = 1'b0;
      total++;
      if (y_valid !== 1'b1 || y_data !== 16'sd25)
         $display("FAIL mid_data: got %0d/v%b want 25/v1", y_data, y_valid);
      else passed++;
      total++;
      if (y_warm !== 1'b0)
         $display("FAIL mid_warm: got %b want 0", y_warm);
      else passed++;
   endtask

   initial begin
      passed  = 0;
      total   = 0;
      rst     = 1'b1;
      x_valid = 1'b0;
      x_data  = '0;
      y_ready = 1'b1;
      test_reset();
      test_step();
      test_extremes();
      test_neg_round();
      test_backpressure();
      test_midreset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
